// File: rtl/mldsa_ahb_cmd_master_if.sv
// Request/response stream plus AHB-lite master signals for mldsa_ahb_cmd_master.
// The master modport is the command master's view; slave is the view of whatever drives it and answers the bus.
interface mldsa_ahb_cmd_master_if #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 64
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [AHB_ADDR_WIDTH-1:0] req_addr;
    logic [31:0]               req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [31:0]               rsp_rdata;
    logic                      rsp_err;
    logic                      hsel_o;
    logic [AHB_ADDR_WIDTH-1:0] haddr_o;
    logic                      hwrite_o;
    logic [1:0]                htrans_o;
    logic [2:0]                hsize_o;
    logic [AHB_DATA_WIDTH-1:0] hwdata_o;
    logic                      hready_i;
    logic                      hresp_i;
    logic [AHB_DATA_WIDTH-1:0] hrdata_i;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  hready_i, hresp_i, hrdata_i,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output hsel_o, haddr_o, hwrite_o, htrans_o, hsize_o, hwdata_o
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output hready_i, hresp_i, hrdata_i,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  hsel_o, haddr_o, hwrite_o, htrans_o, hsize_o, hwdata_o
    );
endinterface

// File: rtl/mldsa_ahb_cmd_master.sv
// Single-outstanding AHB-lite master: one 32-bit word request in, one AHB transfer on the
// 64-bit bus, one response out. All bus and stream outputs come straight from registers.
module mldsa_ahb_cmd_master #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 64
) (
    input logic                   clk,
    input logic                   rst,
    mldsa_ahb_cmd_master_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_ERR2,
        S_RESP
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    state_t                    state_q;
    logic                      write_q;
    logic [AHB_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wdata_q;
    logic                      req_ready_q;
    logic                      rsp_valid_q;
    logic [31:0]               rsp_rdata_q;
    logic                      rsp_err_q;
    logic                      hsel_q;
    logic [AHB_ADDR_WIDTH-1:0] haddr_q;
    logic                      hwrite_q;
    logic [1:0]                htrans_q;
    logic [2:0]                hsize_q;
    logic [AHB_DATA_WIDTH-1:0] hwdata_q;

    // addr[2] picks which 32-bit lane of the 64-bit bus carries the word.
    logic [AHB_DATA_WIDTH-1:0] wdata_lane_d;
    logic [31:0]               rd_lane [2];
    logic [31:0]               rdata_sel_d;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign wdata_lane_d[gi*32 +: 32] = (int'(addr_q[2]) == gi) ? wdata_q : 32'h0;
        assign rd_lane[gi]               = bus.hrdata_i[gi*32 +: 32];
    end
    assign rdata_sel_d = rd_lane[addr_q[2]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            hsel_q      <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            hsize_q     <= HSIZE_WORD;
            hwdata_q    <= '0;
        end else begin
            hsize_q <= HSIZE_WORD;
            case (state_q)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        write_q     <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        if (bus.req_addr[1:0] != 2'b00) begin
                            // Misaligned word: answer with an error without touching the bus.
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q  <= S_ADDR;
                            hsel_q   <= 1'b1;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= bus.req_addr;
                            hwrite_q <= bus.req_write;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.hready_i) begin
                        state_q  <= S_DATA;
                        htrans_q <= HTRANS_IDLE;
                        haddr_q  <= '0;
                        hwrite_q <= 1'b0;
                        hwdata_q <= write_q ? wdata_lane_d : '0;
                    end
                end
                S_DATA: begin
                    if (bus.hready_i) begin
                        state_q     <= S_RESP;
                        hsel_q      <= 1'b0;
                        hwdata_q    <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.hresp_i;
                        rsp_rdata_q <= (write_q || bus.hresp_i) ? 32'h0 : rdata_sel_d;
                    end else if (bus.hresp_i) begin
                        state_q <= S_ERR2;
                    end
                end
                S_ERR2: begin
                    if (bus.hready_i) begin
                        state_q     <= S_RESP;
                        hsel_q      <= 1'b0;
                        hwdata_q    <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.hsel_o    = hsel_q;
    assign bus.haddr_o   = haddr_q;
    assign bus.hwrite_o  = hwrite_q;
    assign bus.htrans_o  = htrans_q;
    assign bus.hsize_o   = hsize_q;
    assign bus.hwdata_o  = hwdata_q;
endmodule

// File: doc/mldsa_ahb_cmd_master.md
Name: mldsa_ahb_cmd_master

Overview:
Single-outstanding AHB-lite master that turns a valid/ready word-request stream into 32-bit AHB-lite transfers on the 64-bit bus of mldsa_top, and returns read data and status on a valid/ready response stream.
It sits directly upstream of mldsa_top's AHB slave port. Firmware-model and integration sequencers use it to load keys and messages, write the CTRL command, and poll status.

Parameters:
AHB_ADDR_WIDTH, 32, AHB address width
AHB_DATA_WIDTH, 64, AHB data width; fixed at 64, with two 32-bit lanes selected by addr[2]

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid & req_ready
req_write  input  1  1 = write, 0 = read
req_addr  input  AHB_ADDR_WIDTH  byte address
req_wdata  input  32  write word
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed
rsp_rdata  output  32  read word (0 for writes and errors)
rsp_err  output  1  hresp error or misaligned address
hsel_o  output  1  AHB select
haddr_o  output  AHB_ADDR_WIDTH  AHB address
hwrite_o  output  1  AHB write
htrans_o  output  2  AHB trans (0 IDLE, 2 NONSEQ)
hsize_o  output  3  AHB size
hwdata_o  output  AHB_DATA_WIDTH  AHB write data
hready_i  input  1  slave hreadyout
hresp_i  input  1  slave error response
hrdata_i  input  AHB_DATA_WIDTH  slave read data

Behaviour:
- Reset values (async): all outputs 0, except hsize_o = 3'b010; FSM goes to IDLE.
- Reset asserted mid-transfer drops the transfer and any pending response.
- All AHB outputs are registered.
- FSM states: IDLE, ADDR, DATA, ERR2, RESP.
- IDLE:
  - req_ready = 1; it is 0 in every other state.
  - On accept, capture write, addr, and wdata.
  - If req_addr[1:0] != 0: no bus transfer; go to RESP with rsp_err = 1 and rsp_rdata = 0.
  - Otherwise go to ADDR.
- ADDR:
  - Drive hsel_o = 1, htrans_o = 2, haddr_o = addr, hwrite_o = write, hsize_o = 3'b010.
  - Hold these until a cycle with hready_i = 1, then go to DATA.
- DATA:
  - htrans_o = 0, hwrite_o = 0, haddr_o = 0; hsel_o stays 1.
  - hwdata_o = addr[2] ? {wdata, 32'h0} : {32'h0, wdata}; driven for writes only, 0 for reads.
  - hready_i = 1 with hresp_i = 0: capture rsp_rdata = addr[2] ? hrdata_i[63:32] : hrdata_i[31:0] (reads only, else 0); set rsp_err = 0; go to RESP.
  - hready_i = 0 with hresp_i = 1 (first error cycle): go to ERR2.
  - hready_i = 0 with hresp_i = 0 (wait state): stay in DATA.
- ERR2:
  - Wait for hready_i = 1 (second error cycle), then set rsp_err = 1, rsp_rdata = 0, and go to RESP.
  - hready_i = 1 together with hresp_i = 1 while still in DATA is also treated as an error: rsp_err = 1, go to RESP.
- RESP:
  - hsel_o = 0, hwdata_o = 0; rsp_valid = 1.
  - rsp_rdata and rsp_err are held stable while rsp_valid & !rsp_ready.
  - On rsp_ready, go to IDLE. A new request is accepted no earlier than the cycle after the handshake.
- Latency with zero wait states: accept at edge N, ADDR during N+1, DATA during N+2, rsp_valid from N+3. Each slave wait cycle adds 1.
- Exactly one transfer is in flight at a time; there are no bursts and no pipelining of address phases.
- req_* inputs are ignored outside IDLE.

Test Plan:
1. Reset with req_valid = 1 -> all outputs 0 and hsize_o = 3'b010; after reset deasserts, req_ready = 1 and there is no bus activity.
2. Write 0x0000_0001 to 0x10, zero-wait slave -> NONSEQ with haddr_o = 0x10, then hwdata_o = 0x0000_0000_0000_0001; rsp_valid 3 cycles after accept, rsp_err = 0.
3. Read 0x4004 with slave returning hrdata_i = 0xDEADBEEF_12345678 after 2 wait cycles -> rsp_rdata = 0xDEADBEEF, rsp_valid 5 cycles after accept.
4. Write to 0x4006 -> no hsel_o/htrans_o activity; rsp_err = 1 on the next RESP cycle.
5. Slave drives a two-cycle error (hresp_i = 1 with hready_i = 0, then hresp_i = 1 with hready_i = 1) -> rsp_err = 1, rsp_rdata = 0. Hold rsp_ready = 0 for 4 cycles -> response stable and req_ready = 0 throughout.
6. Assert rst during DATA with hready_i = 0 -> outputs return to reset values immediately; after release, a 1224-word back-to-back write sequence to 0x4000 + 4*i completes with all rsp_err = 0.
